// File: rtl/clock_bcd_scheduler.sv
// HH:MM:SS timekeeping core. Binary seconds/minutes/hours advanced by a 1 Hz
// prescaler, with a user load port. A single shared 0..59 binary-to-BCD
// converter is time-multiplexed across the three fields by a small FSM, and
// the display outputs are only updated once a full coherent triple is ready.
module clock_bcd_scheduler #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       set_en,
    input  logic [1:0] set_field,
    input  logic [5:0] set_value,
    output logic       set_err,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       bcd_valid,
    output logic       conv_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEC,
        S_MIN,
        S_HR,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [5:0]       ss_q, ss_d;
    logic [5:0]       mm_q, mm_d;
    logic [5:0]       hh_q, hh_d;
    logic             set_err_q, set_err_d;
    logic             tick;
    logic             set_ok;
    logic             time_upd;

    state_t           state_q;
    logic             pending_q;
    logic             pend_take;
    logic [7:0]       sh_ss_q, sh_mm_q, sh_hh_q;
    logic [7:0]       ss_bcd_q, mm_bcd_q, hh_bcd_q;
    logic             bcd_valid_q;

    logic [5:0]       conv_bin;
    logic [3:0]       conv_tens;
    logic [3:0]       conv_units;
    logic [7:0]       conv_bcd;

    // Next-state for prescaler and time registers; an accepted load overrides a tick.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        presc_d  = presc_q;
        ss_d     = ss_q;
        mm_d     = mm_q;
        hh_d     = hh_q;
        time_upd = 1'b0;

        tick   = run && (presc_q == TICK_LAST);
        set_ok = set_en && (((set_field <= 2'd1) && (set_value <= 6'd59)) ||
                            ((set_field == 2'd2) && (set_value <= 6'd23)));
        set_err_d = set_en && !set_ok;

        if (!run || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (set_ok) begin
            presc_d  = '0;
            time_upd = 1'b1;
            case (set_field)
                2'd0:    ss_d = set_value;
                2'd1:    mm_d = set_value;
                default: hh_d = set_value;
            endcase
        end else if (tick) begin
            time_upd = 1'b1;
            if (ss_q == 6'd59) begin
                ss_d = 6'd0;
                if (mm_q == 6'd59) begin
                    mm_d = 6'd0;
                    hh_d = (hh_q == 6'd23) ? 6'd0 : hh_q + 6'd1;
                end else begin
                    mm_d = mm_q + 6'd1;
                end
            end else begin
                ss_d = ss_q + 6'd1;
            end
        end
    end

    // Time registers, prescaler and the load-reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            ss_q      <= 6'd0;
            mm_q      <= 6'd0;
            hh_q      <= 6'd0;
            set_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            presc_q   <= presc_d;
            ss_q      <= ss_d;
            mm_q      <= mm_d;
            hh_q      <= hh_d;
            set_err_q <= set_err_d;
        end
    end

    // Shared converter: the field is selected by state, 0 while idle; inputs stay below 60.
    always_comb begin
        conv_bin = 6'd0;
        case (state_q)
            S_SEC:   conv_bin = ss_q;
            S_MIN:   conv_bin = mm_q;
            S_HR:    conv_bin = hh_q;
            default: conv_bin = 6'd0;
        endcase

        conv_tens  = 4'd0;
        conv_units = conv_bin[3:0];
        if (conv_bin >= 6'd50) begin
            conv_tens  = 4'd5;
            conv_units = 4'(conv_bin - 6'd50);
        end else if (conv_bin >= 6'd40) begin
            conv_tens  = 4'd4;
            conv_units = 4'(conv_bin - 6'd40);
        end else if (conv_bin >= 6'd30) begin
            conv_tens  = 4'd3;
            conv_units = 4'(conv_bin - 6'd30);
        end else if (conv_bin >= 6'd20) begin
            conv_tens  = 4'd2;
            conv_units = 4'(conv_bin - 6'd20);
        end else if (conv_bin >= 6'd10) begin
            conv_tens  = 4'd1;
            conv_units = 4'(conv_bin - 6'd10);
        end
        conv_bcd = {conv_tens, conv_units};
    end

    // Pending is consumed whenever the FSM starts a pass (from idle or back-to-back from done).
    assign pend_take = (state_q == S_IDLE) || (state_q == S_DONE);

    // Conversion sequencer: capture shadows field by field, publish all three together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            sh_ss_q     <= 8'h00;
            sh_mm_q     <= 8'h00;
            sh_hh_q     <= 8'h00;
            ss_bcd_q    <= 8'h00;
            mm_bcd_q    <= 8'h00;
            hh_bcd_q    <= 8'h00;
            bcd_valid_q <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            // A fresh update always wins over consumption, so at most one extra pass queues.
            pending_q   <= time_upd | (pending_q & ~pend_take);
            case (state_q)
                S_IDLE: begin
                    if (pending_q) state_q <= S_SEC;
                end
                S_SEC: begin
                    sh_ss_q <= conv_bcd;
                    state_q <= S_MIN;
                end
                S_MIN: begin
                    sh_mm_q <= conv_bcd;
                    state_q <= S_HR;
                end
                S_HR: begin
                    sh_hh_q <= conv_bcd;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    ss_bcd_q    <= sh_ss_q;
                    mm_bcd_q    <= sh_mm_q;
                    hh_bcd_q    <= sh_hh_q;
                    bcd_valid_q <= 1'b1;
                    state_q     <= pending_q ? S_SEC : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign set_err   = set_err_q;
    assign hh_bcd    = hh_bcd_q;
    assign mm_bcd    = mm_bcd_q;
    assign ss_bcd    = ss_bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign conv_busy = (state_q != S_IDLE);

endmodule
